data_shifter_scale_ctrl: RTL and testbench

//  Automatic scaling controller for the single-stage data shifter (88b accumulator -> 32b output).

---
 rtl/data_shifter_scale_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_data_shifter_scale_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/data_shifter_scale_ctrl.sv
// ----------------------------------------------------------------------------
// data_shifter_scale_ctrl
//
// Automatic scaling controller for the single-stage data shifter that reduces
// a wide decimation accumulator sample to a narrow output word. It tracks the
// peak magnitude of valid samples over a window of 2**WINDOW_LOG2 samples. It
// then derives the largest left-shift distance that still keeps HEADROOM spare
// bits below the sign bit. Each sample is registered together with the
// distance applied to it, so the shifter always sees a consistent pair.
//
// Ports
//   clk_in           in   system clock
//   rst_n            in   asynchronous active-low reset
//   sample_in        in   signed two's-complement sample, IN_WIDTH bits
//   sample_valid     in   sample_in qualifier
//   manual_en        in   1 = use manual_distance, automatic update suppressed
//   manual_distance  in   requested manual distance (clamped to MAX_DIST)
//   sample_out       out  registered sample towards the shifter
//   sample_out_valid out  sample_out qualifier
//   distance_out     out  shift distance paired with sample_out
//   gain_drop        out  one-cycle pulse when auto mode reduces the distance
//   window_overrun   out  sticky flag: a window closed while a result was busy
// ----------------------------------------------------------------------------
module data_shifter_scale_ctrl #(
   parameter int IN_WIDTH     = 88,
   parameter int OUT_WIDTH    = 32,
   parameter int WINDOW_LOG2  = 12,
   parameter int HEADROOM     = 2,
   parameter int HOLD_WINDOWS = 4,
   parameter int INIT_DIST    = 0
) (
   input  logic                clk_in,
   input  logic                rst_n,
   input  logic [IN_WIDTH-1:0] sample_in,
   input  logic                sample_valid,
   input  logic                manual_en,
   input  logic [7:0]          manual_distance,
   output logic [IN_WIDTH-1:0] sample_out,
   output logic                sample_out_valid,
   output logic [7:0]          distance_out,
   output logic                gain_drop,
   output logic                window_overrun
);

   localparam int                MAX_DIST   = IN_WIDTH - OUT_WIDTH;
   localparam logic [7:0]        MAX_DIST8  = 8'(MAX_DIST);
   localparam logic [7:0]        INIT_DIST8 = 8'(INIT_DIST);
   localparam logic [7:0]        TOP_IDX8   = 8'(IN_WIDTH - 2 - HEADROOM);
   localparam int                IDX_W      = $clog2(IN_WIDTH);
   localparam logic [IDX_W-1:0]  SCAN_START = IDX_W'(IN_WIDTH - 2);
   localparam int                HOLD_W     = $clog2(HOLD_WINDOWS + 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_WINDOWS);

   typedef enum logic [1:0] {
      ACCUM,
      CALC,
      APPLY
   } state_t;

   state_t                 state;
   logic [WINDOW_LOG2-1:0] win_cnt;
   logic [IN_WIDTH-1:0]    live_peak;
   logic [IN_WIDTH-1:0]    snapshot;
   logic [IDX_W-1:0]       scan_idx;
   logic [7:0]             target;
   logic [7:0]             cur_dist;
   logic [HOLD_W-1:0]      hold_cnt;
   logic [7:0]             hold_min;

   logic [IN_WIDTH-1:0]    mag;
   logic                   window_close;
   logic                   scan_hit;
   logic                   scan_done;
   logic [7:0]             scan_target;
   logic [7:0]             manual_clamped;
   logic [HOLD_W-1:0]      hold_next;
   logic [7:0]             hold_min_next;

   // Ones' complement magnitude: cheaper than negation and only ever one LSB
   // low, which cannot move the leading one by more than the headroom allows.
   assign mag = sample_in ^ {IN_WIDTH{sample_in[IN_WIDTH-1]}};

   // The window counter wraps to zero by itself on the closing sample.
   assign window_close   = sample_valid && (win_cnt == '1);
   assign scan_hit       = snapshot[scan_idx];
   assign scan_done      = scan_hit || (scan_idx == '0);
   assign manual_clamped = (manual_distance > MAX_DIST8) ? MAX_DIST8 : manual_distance;
   assign hold_next      = hold_cnt + 1'b1;
   assign hold_min_next  = (target < hold_min) ? target : hold_min;

   // Distance for the bit currently under the scan pointer. A scan that runs
   // out at bit 0 without a hit means an all-zero peak, so full gain is safe.
   always_comb begin
      scan_target = MAX_DIST8;
      if (scan_hit) begin
         if (8'(scan_idx) >= TOP_IDX8) begin
            scan_target = 8'd0;
         end else if ((TOP_IDX8 - 8'(scan_idx)) > MAX_DIST8) begin
            scan_target = MAX_DIST8;
         end else begin
            scan_target = TOP_IDX8 - 8'(scan_idx);
         end
      end
   end

   // Measurement, leading-one scan and distance decision.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state          <= ACCUM;
         win_cnt        <= '0;
         live_peak      <= '0;
         snapshot       <= '0;
         scan_idx       <= SCAN_START;
         target         <= 8'd0;
         cur_dist       <= INIT_DIST8;
         hold_cnt       <= '0;
         hold_min       <= MAX_DIST8;
         gain_drop      <= 1'b0;
         window_overrun <= 1'b0;
      end else begin
         gain_drop <= 1'b0;

         if (sample_valid) begin
            win_cnt   <= win_cnt + 1'b1;
            live_peak <= window_close ? '0 : (live_peak | mag);
         end

         // A closing window is only captured when the previous result is done;
         // otherwise it is dropped and the overrun is remembered.
         if (window_close && (state != ACCUM)) begin
            window_overrun <= 1'b1;
         end

         case (state)
            ACCUM: begin
               if (window_close) begin
                  snapshot <= live_peak | mag;
                  scan_idx <= SCAN_START;
                  state    <= CALC;
               end
            end
            CALC: begin
               if (scan_done) begin
                  target <= scan_target;
                  state  <= APPLY;
               end else begin
                  scan_idx <= scan_idx - 1'b1;
               end
            end
            APPLY: begin
               state <= ACCUM;
               if (!manual_en) begin
                  // Gain is cut at once but only raised after HOLD_WINDOWS
                  // windows agree, using the most cautious of their targets.
                  if (target < cur_dist) begin
                     cur_dist  <= target;
                     gain_drop <= 1'b1;
                     hold_cnt  <= '0;
                     hold_min  <= MAX_DIST8;
                  end else if (target > cur_dist) begin
                     if (hold_next == HOLD_LAST) begin
                        cur_dist <= hold_min_next;
                        hold_cnt <= '0;
                        hold_min <= MAX_DIST8;
                     end else begin
                        hold_cnt <= hold_next;
                        hold_min <= hold_min_next;
                     end
                  end else begin
                     hold_cnt <= '0;
                     hold_min <= MAX_DIST8;
                  end
               end
            end
            default: state <= ACCUM;
         endcase

         // Manual mode owns the distance; keeping the hold history clear means
         // auto mode restarts cleanly from the manual value.
         if (manual_en) begin
            cur_dist <= manual_clamped;
            hold_cnt <= '0;
            hold_min <= MAX_DIST8;
         end
      end
   end

   // Sample/distance pairing register; the distance only moves with a sample.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         sample_out       <= '0;
         sample_out_valid <= 1'b0;
         distance_out     <= INIT_DIST8;
      end else if (sample_valid) begin
         sample_out       <= sample_in;
         sample_out_valid <= 1'b1;
         distance_out     <= cur_dist;
      end else begin
         sample_out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_data_shifter_scale_ctrl.sv
// ----------------------------------------------------------------------------
// tb_data_shifter_scale_ctrl
//
// Directed self-checking bench for data_shifter_scale_ctrl with a 128-sample
// window and a two-window hold. A vector table covers the pass-through path.
// Hand-written window sequences cover the distance decisions, the manual
// override and reset during a scan.
// ----------------------------------------------------------------------------
module tb_data_shifter_scale_ctrl;

   localparam int W = 88;

   localparam logic [W-1:0] P40   = W'(1) << 40;
   localparam logic [W-1:0] P70   = W'(1) << 70;
   localparam logic [W-1:0] P80   = W'(1) << 80;
   localparam logic [W-1:0] NEG40 = ~P40 + W'(1);
   localparam logic [W-1:0] ALL1  = '1;
   localparam logic [W-1:0] ZERO  = '0;

   logic          clk_in = 1'b0;
   logic          rst_n;
   logic [W-1:0]  sample_in;
   logic          sample_valid;
   logic          manual_en;
   logic [7:0]    manual_distance;
   logic [W-1:0]  sample_out;
   logic          sample_out_valid;
   logic [7:0]    distance_out;
   logic          gain_drop;
   logic          window_overrun;

   int checks = 0;
   int errors = 0;
   int drop_count = 0;

   typedef struct {
      logic         valid;
      logic [W-1:0] sample;
      logic [W-1:0] exp_out;
      logic         exp_valid;
      logic [7:0]   exp_dist;
   } vec_t;

   vec_t vecs[8];

   data_shifter_scale_ctrl #(
      .IN_WIDTH    (88),
      .OUT_WIDTH   (32),
      .WINDOW_LOG2 (7),
      .HEADROOM    (2),
      .HOLD_WINDOWS(2),
      .INIT_DIST   (0)
   ) dut (
      .clk_in          (clk_in),
      .rst_n           (rst_n),
      .sample_in       (sample_in),
      .sample_valid    (sample_valid),
      .manual_en       (manual_en),
      .manual_distance (manual_distance),
      .sample_out      (sample_out),
      .sample_out_valid(sample_out_valid),
      .distance_out    (distance_out),
      .gain_drop       (gain_drop),
      .window_overrun  (window_overrun)
   );

   always #5 clk_in = ~clk_in;

   // Count cycles with gain_drop high, away from the active edge.
   always @(negedge clk_in) begin
      if (rst_n && gain_drop) drop_count++;
   end

   task automatic checkVal(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic checkOutput(input string name, input logic [W-1:0] exp_s,
                              input logic exp_v, input logic [7:0] exp_d);
      checkVal({name, " sample_out"}, sample_out, exp_s);
      checkVal({name, " valid"}, W'(sample_out_valid), W'(exp_v));
      checkVal({name, " distance"}, W'(distance_out), W'(exp_d));
   endtask

   task automatic checkResetState(input string name);
      checkOutput(name, ZERO, 1'b0, 8'd0);
      checkVal({name, " gain_drop"}, W'(gain_drop), W'(0));
      checkVal({name, " overrun"}, W'(window_overrun), W'(0));
   endtask

   // Drive one cycle of input and return 1 time unit after the capturing edge.
   task automatic applyStimulus(input logic v, input logic [W-1:0] s);
      sample_valid = v;
      sample_in    = s;
      @(posedge clk_in);
      #1;
   endtask

   task automatic idleCycles(input int n);
      sample_valid = 1'b0;
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   // Back-to-back valid samples; sample 0 (and every even one when alternate
   // is set) is 'first', the rest are 'rest'. Each output pair is checked.
   task automatic streamWindow(input string name, input logic [W-1:0] first,
                               input logic [W-1:0] rest, input int n,
                               input logic [7:0] first_dist, input logic [7:0] rest_dist,
                               input logic alternate);
      logic [W-1:0] s;
      for (int i = 0; i < n; i++) begin
         s = ((i == 0) || (alternate && (i % 2 == 0))) ? first : rest;
         applyStimulus(1'b1, s);
         checkOutput($sformatf("%s[%0d]", name, i), s, 1'b1,
                     (i == 0) ? first_dist : rest_dist);
      end
   endtask

   initial begin
      vecs[0] = '{1'b1, W'(5),     W'(5),     1'b1, 8'd0};
      vecs[1] = '{1'b0, W'('h77),  W'(5),     1'b0, 8'd0};
      vecs[2] = '{1'b1, ~W'(2),    ~W'(2),    1'b1, 8'd0};
      vecs[3] = '{1'b1, W'('hAB),  W'('hAB),  1'b1, 8'd0};
      vecs[4] = '{1'b0, W'(0),     W'('hAB),  1'b0, 8'd0};
      vecs[5] = '{1'b0, W'('hFFFF),W'('hAB),  1'b0, 8'd0};
      vecs[6] = '{1'b1, W'(1),     W'(1),     1'b1, 8'd0};
      vecs[7] = '{1'b1, W'('h12),  W'('h12),  1'b1, 8'd0};

      rst_n           = 1'b0;
      sample_in       = '0;
      sample_valid    = 1'b0;
      manual_en       = 1'b0;
      manual_distance = 8'd0;
      #2;
      checkResetState("reset");
      repeat (2) @(posedge clk_in);
      #1;
      rst_n = 1'b1;

      // Pass-through table: five valid samples land in the first window.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i].valid, vecs[i].sample);
         checkOutput($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_valid, vecs[i].exp_dist);
      end

      // Close the window with a small peak so the scan runs long, then load
      // the next window with a big value and reset in the middle of the scan.
      streamWindow("fill", W'(3), W'(3), 123, 8'd0, 8'd0, 1'b0);
      streamWindow("precalc", P80, P80, 10, 8'd0, 8'd0, 1'b0);
      rst_n        = 1'b0;
      sample_valid = 1'b0;
      #1;
      checkResetState("midcalc_reset");
      repeat (2) @(posedge clk_in);
      #1;
      rst_n = 1'b1;

      // Two windows at bit 40: target 44, raised only after the second APPLY.
      streamWindow("w1w2", P40, P40, 256, 8'd0, 8'd0, 1'b0);
      idleCycles(100);
      checkOutput("hold_after_w2", P40, 1'b0, 8'd0);
      checkVal("no_drop_w2", W'(drop_count), W'(0));

      // One bit-70 sample: target 14, immediate drop with a pulse.
      streamWindow("w3", P70, P40, 128, 8'd44, 8'd44, 1'b0);
      idleCycles(100);
      checkOutput("hold_after_w3", P40, 1'b0, 8'd44);
      checkVal("drop_w3", W'(drop_count), W'(1));

      // Negative window (target 45) then zero/-1 window (target 56): the
      // raise uses the smaller of the two held targets.
      streamWindow("w4", NEG40, NEG40, 128, 8'd14, 8'd14, 1'b0);
      idleCycles(100);
      checkOutput("hold_after_w4", NEG40, 1'b0, 8'd14);
      streamWindow("w5", ZERO, ALL1, 128, 8'd14, 8'd14, 1'b1);
      idleCycles(100);
      checkOutput("hold_after_w5", ALL1, 1'b0, 8'd14);
      checkVal("drop_w5", W'(drop_count), W'(1));

      // Manual enable raised together with a sample: that sample keeps 45,
      // later ones get the clamped 56; the bit-70 window is ignored.
      manual_en       = 1'b1;
      manual_distance = 8'd200;
      streamWindow("w6_manual", P70, P70, 128, 8'd45, 8'd56, 1'b0);
      idleCycles(100);
      checkOutput("hold_after_w6", P70, 1'b0, 8'd56);
      checkVal("drop_w6", W'(drop_count), W'(1));

      // Manual 30, then back to auto: two zero windows lift it to 56.
      manual_distance = 8'd30;
      idleCycles(1);
      streamWindow("w7_manual30", ZERO, ZERO, 1, 8'd30, 8'd30, 1'b0);
      manual_en = 1'b0;
      streamWindow("w7_auto", ZERO, ZERO, 127, 8'd30, 8'd30, 1'b0);
      idleCycles(100);
      checkOutput("hold_after_w7", ZERO, 1'b0, 8'd30);
      streamWindow("w8", ALL1, ALL1, 128, 8'd30, 8'd30, 1'b0);
      idleCycles(100);
      checkOutput("hold_after_w8", ALL1, 1'b0, 8'd30);
      streamWindow("final", ZERO, ZERO, 1, 8'd56, 8'd56, 1'b0);

      checkVal("overrun", W'(window_overrun), W'(0));
      checkVal("drop_total", W'(drop_count), W'(1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
